// File: rtl/load_store_unit_if.sv
// Request/response and data-memory port bundle between the execute stage,
// the load/store unit and the 128x32 data memory.
interface load_store_unit_if #(
    parameter int WORD_ADDR_W = 7
);
    logic                   ReqValid;
    logic                   ReqReady;
    logic                   ReqWrite;
    logic [1:0]             ReqSize;
    logic                   ReqUnsigned;
    logic [WORD_ADDR_W+1:0] ReqAddr;
    logic [31:0]            ReqData;

    logic                   RspValid;
    logic                   RspReady;
    logic [31:0]            RspData;
    logic                   RspErr;

    logic [WORD_ADDR_W-1:0] MemAddress;
    logic [31:0]            MemWriteData;
    logic                   MemRead;
    logic                   MemWrite;
    logic [31:0]            MemReadData;

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and once raised the payload holds
    // until the transfer edge.
    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqData,
        output ReqReady,
        output RspValid, RspData, RspErr,
        input  RspReady,
        output MemAddress, MemWriteData, MemRead, MemWrite,
        input  MemReadData
    );

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqUnsigned, ReqAddr, ReqData,
        input  ReqReady,
        input  RspValid, RspData, RspErr,
        output RspReady,
        input  MemAddress, MemWriteData, MemRead, MemWrite,
        output MemReadData
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store stage in front of a word-addressed registered-read memory:
// lane extraction with extension, read-modify-write sub-word stores, alignment checks.
module load_store_unit #(
    parameter int WORD_ADDR_W = 7
) (
    input  logic             Clk,
    input  logic             ResetN,
    load_store_unit_if.slave bus,
    output logic [2:0]       dbg_state
);
    localparam int BAW = WORD_ADDR_W + 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic                   req_ready_q, req_ready_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_data_q, rsp_data_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [WORD_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]            mem_wdata_q, mem_wdata_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic                   write_q, write_d;
    logic [1:0]             size_q, size_d;
    logic                   unsigned_q, unsigned_d;
    logic [1:0]             lane_q, lane_d;
    logic [15:0]            data_q, data_d;

    logic        accept;
    logic        req_err;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    assign accept  = bus.ReqValid & req_ready_q;
    assign req_err = (bus.ReqSize == 2'b11)
                   | ((bus.ReqSize == 2'b01) & bus.ReqAddr[0])
                   | ((bus.ReqSize == 2'b10) & (bus.ReqAddr[1:0] != 2'b00));

    // Lane datapath, driven by the captured request and the memory read word.
    always_comb begin
        lane_byte = bus.MemReadData[{lane_q, 3'b000} +: 8];
        lane_half = bus.MemReadData[{lane_q[1], 4'b0000} +: 16];
        load_val  = bus.MemReadData;
        merged    = bus.MemReadData;
        case (size_q)
            2'b00: begin
                load_val = {{24{lane_byte[7] & ~unsigned_q}}, lane_byte};
                merged[{lane_q, 3'b000} +: 8] = data_q[7:0];
            end
            2'b01: begin
                load_val = {{16{lane_half[15] & ~unsigned_q}}, lane_half};
                merged[{lane_q[1], 4'b0000} +: 16] = data_q;
            end
            default: begin
                load_val = bus.MemReadData;
                merged   = bus.MemReadData;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        write_d     = write_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        lane_d      = lane_q;
        data_d      = data_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d    = bus.ReqWrite;
                    size_d     = bus.ReqSize;
                    unsigned_d = bus.ReqUnsigned;
                    lane_d     = bus.ReqAddr[1:0];
                    data_d     = bus.ReqData[15:0];
                    mem_addr_d = bus.ReqAddr[BAW-1:2];
                    rsp_data_d = 32'h0;
                    rsp_err_d  = 1'b0;
                    if (req_err) begin
                        // Rejected requests answer at once and never touch memory.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else if (bus.ReqWrite && (bus.ReqSize == 2'b10)) begin
                        state_d     = WRITE;
                        mem_write_d = 1'b1;
                        mem_wdata_d = bus.ReqData;
                    end else begin
                        state_d    = READ;
                        mem_read_d = 1'b1;
                    end
                end
            end
            READ: begin
                state_d = MERGE;
            end
            MERGE: begin
                if (write_q) begin
                    state_d     = WRITE;
                    mem_write_d = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = load_val;
                    rsp_err_d   = 1'b0;
                end
            end
            WRITE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = 32'h0;
                rsp_err_d   = 1'b0;
            end
            RESP: begin
                if (bus.RspReady) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'h0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= 2'b00;
            unsigned_q  <= 1'b0;
            lane_q      <= 2'b00;
            data_q      <= 16'h0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            write_q     <= write_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            lane_q      <= lane_d;
            data_q      <= data_d;
        end
    end

    assign bus.ReqReady     = req_ready_q;
    assign bus.RspValid     = rsp_valid_q;
    assign bus.RspData      = rsp_data_q;
    assign bus.RspErr       = rsp_err_q;
    assign bus.MemAddress   = mem_addr_q;
    assign bus.MemWriteData = mem_wdata_q;
    assign bus.MemRead      = mem_read_q;
    assign bus.MemWrite     = mem_write_q;
    assign dbg_state        = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a
// byte-level reference model of the 128-word memory.
module tb_load_store_unit;
    localparam int AW  = 7;
    localparam int BAW = AW + 2;

    logic       Clk;
    logic       ResetN;
    logic [2:0] dbg_state;

    load_store_unit_if #(.WORD_ADDR_W(AW)) bus ();

    load_store_unit #(.WORD_ADDR_W(AW)) dut (
        .Clk       (Clk),
        .ResetN    (ResetN),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- memory model (registered read) ----------------
    logic [31:0] mem_arr [128];
    always @(posedge Clk) begin
        if (bus.MemWrite) mem_arr[bus.MemAddress] <= bus.MemWriteData;
        if (bus.MemRead)  bus.MemReadData <= mem_arr[bus.MemAddress];
    end

    // ---------------- scoreboard ----------------
    int          total;
    int          bad;
    int          waited;
    logic [31:0] ref_mem [128];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: what a request should do, from byte offsets and masks.
    function automatic void model(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [BAW-1:0] a, input logic [31:0] d,
                                  output logic [31:0] rdata, output logic err,
                                  output int lat, output int nrd, output int nwr,
                                  output logic [31:0] wdata);
        int          ofs;
        int          sh;
        logic [31:0] old;
        logic [31:0] mask;
        logic [31:0] lane;
        ofs   = int'(a) % 4;
        old   = ref_mem[int'(a) / 4];
        sh    = ofs * 8;
        mask  = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
        rdata = 32'h0;
        wdata = 32'h0;
        nrd   = 0;
        nwr   = 0;
        err   = (sz == 2'd3) || (sz == 2'd1 && (ofs % 2) != 0) || (sz == 2'd2 && ofs != 0);
        if (err) begin
            lat = 1;
        end else if (w && sz == 2'd2) begin
            lat = 2; nwr = 1; wdata = d;
        end else if (w) begin
            lat = 4; nrd = 1; nwr = 1;
            wdata = (old & ~(mask << sh)) | ((d & mask) << sh);
        end else begin
            lat = 3; nrd = 1;
            if (sz == 2'd2) lane = old;
            else            lane = (old >> sh) & mask;
            if (!u && sz == 2'd0 && lane >= 32'h80)   lane = lane - 32'h100;
            if (!u && sz == 2'd1 && lane >= 32'h8000) lane = lane - 32'h10000;
            rdata = lane;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic run_req(input logic w, input logic [1:0] sz, input logic u,
                           input logic [BAW-1:0] a, input logic [31:0] d,
                           input int hold, input logic keep_valid);
        logic [31:0] e_rd, e_wd, wd_seen;
        logic        e_err, both, addr_bad;
        int          e_lat, e_nrd, e_nwr, lat, nrd, nwr;
        model(w, sz, u, a, d, e_rd, e_err, e_lat, e_nrd, e_nwr, e_wd);

        bus.ReqValid    = 1'b1;
        bus.ReqWrite    = w;
        bus.ReqSize     = sz;
        bus.ReqUnsigned = u;
        bus.ReqAddr     = a;
        bus.ReqData     = d;
        bus.RspReady    = (hold == 0);

        waited = 0;
        while (!bus.ReqReady && waited < 50) begin
            @(posedge Clk); #1;
            waited++;
        end
        check("accept_wait", 32'(waited < 50), 32'd1);
        @(posedge Clk); #1;
        if (!keep_valid) bus.ReqValid = 1'b0;
        bus.ReqWrite    = 1'($urandom);
        bus.ReqSize     = 2'($urandom);
        bus.ReqUnsigned = 1'($urandom);
        bus.ReqAddr     = BAW'($urandom);
        bus.ReqData     = $urandom;

        lat = 1; nrd = 0; nwr = 0; both = 1'b0; addr_bad = 1'b0; wd_seen = 32'h0;
        forever begin
            if (bus.MemRead) nrd++;
            if (bus.MemWrite) begin
                nwr++;
                wd_seen = bus.MemWriteData;
            end
            if (bus.MemRead && bus.MemWrite) both = 1'b1;
            if (bus.MemAddress !== a[BAW-1:2]) addr_bad = 1'b1;
            if (bus.RspValid || lat >= 12) break;
            @(posedge Clk); #1;
            lat++;
        end
        check("rsp_valid", 32'(bus.RspValid), 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("read_pulses", 32'(nrd), 32'(e_nrd));
        check("write_pulses", 32'(nwr), 32'(e_nwr));
        check("strobe_overlap", 32'(both), 32'd0);
        check("addr_stable", 32'(addr_bad), 32'd0);
        check("rsp_err", 32'(bus.RspErr), 32'(e_err));
        check("rsp_data", bus.RspData, e_rd);
        if (e_nwr != 0) check("write_data", wd_seen, e_wd);

        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            check("hold_valid", 32'(bus.RspValid), 32'd1);
            check("hold_data", bus.RspData, e_rd);
            check("hold_ready", 32'(bus.ReqReady), 32'd0);
            check("hold_noread", 32'(bus.MemRead), 32'd0);
        end
        bus.RspReady = 1'b1;
        @(posedge Clk); #1;
        check("post_valid", 32'(bus.RspValid), 32'd0);
        check("post_ready", 32'(bus.ReqReady), 32'd1);
        bus.RspReady = 1'b0;
        if (e_nwr != 0) ref_mem[int'(a) / 4] = e_wd;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        total = 0;
        bad   = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
        ResetN          = 1'b0;
        bus.ReqValid    = 1'b0;
        bus.ReqWrite    = 1'b0;
        bus.ReqSize     = 2'b00;
        bus.ReqUnsigned = 1'b0;
        bus.ReqAddr     = '0;
        bus.ReqData     = 32'h0;
        bus.RspReady    = 1'b0;

        #2;
        check("rst_req_ready", 32'(bus.ReqReady), 32'd0);
        check("rst_rsp_valid", 32'(bus.RspValid), 32'd0);
        check("rst_rsp_err", 32'(bus.RspErr), 32'd0);
        check("rst_mem_read", 32'(bus.MemRead), 32'd0);
        check("rst_mem_write", 32'(bus.MemWrite), 32'd0);
        check("rst_rsp_data", bus.RspData, 32'h0);
        check("rst_mem_addr", 32'(bus.MemAddress), 32'd0);
        check("rst_mem_wdata", bus.MemWriteData, 32'h0);
        #20 ResetN = 1'b1;
        @(posedge Clk); #1;

        // Fill every word through the unit so model and memory agree.
        for (int i = 0; i < 128; i++)
            run_req(1'b1, 2'd2, 1'b0, BAW'(i * 4), $urandom, 0, 1'b0);

        // Directed: word store, then loads of each width.
        run_req(1'b1, 2'd2, 1'b0, 9'h010, 32'hDEADBEEF, 0, 1'b0);
        check("mem_word4", mem_arr[4], 32'hDEADBEEF);
        run_req(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 0, 1'b0);
        run_req(1'b0, 2'd0, 1'b0, 9'h013, 32'h0, 0, 1'b0);
        run_req(1'b0, 2'd0, 1'b1, 9'h013, 32'h0, 0, 1'b0);
        run_req(1'b0, 2'd1, 1'b0, 9'h012, 32'h0, 0, 1'b0);
        run_req(1'b1, 2'd0, 1'b0, 9'h011, 32'h00000055, 0, 1'b0);
        check("mem_word4_rmw", mem_arr[4], 32'hDEAD55EF);
        run_req(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 0, 1'b0);

        // Misaligned and reserved-size requests.
        run_req(1'b0, 2'd1, 1'b0, 9'h011, 32'h0, 0, 1'b0);
        run_req(1'b1, 2'd2, 1'b0, 9'h012, 32'h12345678, 0, 1'b0);
        run_req(1'b0, 2'd3, 1'b0, 9'h010, 32'h0, 0, 1'b0);
        check("mem_word4_err", mem_arr[4], 32'hDEAD55EF);

        // Response back-pressure with the next request already waiting.
        run_req(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 5, 1'b1);
        run_req(1'b0, 2'd0, 1'b1, 9'h011, 32'h0, 0, 1'b0);
        check("back_to_back_wait", 32'(waited), 32'd0);

        // Reset while a sub-word store is in its write cycle.
        bus.ReqValid    = 1'b1;
        bus.ReqWrite    = 1'b1;
        bus.ReqSize     = 2'd0;
        bus.ReqUnsigned = 1'b0;
        bus.ReqAddr     = 9'h011;
        bus.ReqData     = 32'h000000AA;
        bus.RspReady    = 1'b1;
        n = 0;
        while (!bus.ReqReady && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        @(posedge Clk); #1;
        bus.ReqValid = 1'b0;
        n = 0;
        while (!bus.MemWrite && n < 10) begin
            @(posedge Clk); #1;
            n++;
        end
        check("rst_mid_reached_write", 32'(bus.MemWrite), 32'd1);
        #2 ResetN = 1'b0;
        #1;
        check("rst_mid_write_drop", 32'(bus.MemWrite), 32'd0);
        check("rst_mid_read_drop", 32'(bus.MemRead), 32'd0);
        check("rst_mid_ready", 32'(bus.ReqReady), 32'd0);
        check("rst_mid_rsp_valid", 32'(bus.RspValid), 32'd0);
        @(posedge Clk); @(posedge Clk); #1;
        check("rst_mid_mem_kept", mem_arr[4], ref_mem[4]);
        check("rst_mid_mem_value", mem_arr[4], 32'hDEAD55EF);
        @(negedge Clk);
        ResetN       = 1'b1;
        bus.RspReady = 1'b0;
        @(posedge Clk); @(posedge Clk); #1;
        check("rst_rel_ready", 32'(bus.ReqReady), 32'd1);
        check("rst_rel_rsp_valid", 32'(bus.RspValid), 32'd0);
        run_req(1'b0, 2'd2, 1'b0, 9'h010, 32'h0, 0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            logic [1:0] sz;
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            run_req(1'($urandom), sz, 1'($urandom), BAW'($urandom), $urandom,
                    $urandom_range(0, 3), 1'b0);
        end

        for (int i = 0; i < 128; i++) check("final_mem", mem_arr[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-access stage placed directly upstream of the 128x32 data memory. Accepts byte/half/word load and store requests from the execute stage over a valid/ready handshake. Drives the memory's word-addressed, single-cycle, registered-read port. Performs byte-lane extraction with sign or zero extension, read-modify-write for sub-word stores, and misalignment checking.

Parameters:
WORD_ADDR_W, 7, memory word-address width; request byte address is WORD_ADDR_W+2 bits.

Ports:
Clk  input  1  clock, rising edge
ResetN  input  1  asynchronous active-low reset
ReqValid  input  1  request valid
ReqReady  output  1  request accepted when ReqValid&ReqReady at a rising edge
ReqWrite  input  1  1=store, 0=load
ReqSize  input  2  00=byte, 01=half, 10=word, 11=reserved
ReqUnsigned  input  1  loads: 1=zero-extend, 0=sign-extend
ReqAddr  input  WORD_ADDR_W+2  byte address, little-endian
ReqData  input  32  store data, right-aligned
RspValid  output  1  response valid
RspReady  input  1  response consumed when RspValid&RspReady at a rising edge
RspData  output  32  load result; 0 for stores and errors
RspErr  output  1  misaligned access or reserved size
MemAddress  output  WORD_ADDR_W  word address = ReqAddr[WORD_ADDR_W+1:2]
MemWriteData  output  32  word to write
MemRead  output  1  memory read strobe
MemWrite  output  1  memory write strobe
MemReadData  input  32  memory data, valid in the cycle after a MemRead edge

Behaviour:
- Reset (ResetN low, async): state=IDLE; ReqReady, RspValid, RspErr, MemRead, MemWrite = 0; RspData, MemAddress, MemWriteData = 0. ReqReady is forced 0 while ResetN is low.
- All outputs are registered; ReqReady = (state==IDLE).
- All request fields are captured on the accept edge; later input changes are ignored.
- Error check at accept: size 11, half with ReqAddr[0]=1, or word with ReqAddr[1:0]!=0 -> error. An erroring request performs no memory access.
- States: IDLE, READ, MERGE, WRITE, RESP.
- IDLE, on accept:
  - Error -> RESP with RspErr=1, RspData=0.
  - Load or sub-word store -> READ, MemRead=1.
  - Word store -> WRITE, MemWrite=1, MemWriteData=ReqData.
- READ: MemRead is high for exactly this one cycle; -> MERGE with MemRead=0.
- MERGE: MemReadData is valid.
  - Load: RspData = selected lane extended; byte lane = addr[1:0]*8, half lane = addr[1]*16; -> RESP.
  - Sub-word store: MemWriteData = MemReadData with the selected lane replaced by ReqData[7:0] or ReqData[15:0]; MemWrite=1; -> WRITE.
- WRITE: MemWrite is high for exactly this one cycle; -> RESP with RspData=0, RspErr=0.
- RESP: RspValid=1 with RspData/RspErr stable until RspReady; on handshake -> IDLE with RspValid=0.
- Latency, counted from the accept edge to RspValid rising:
  - error: 1 edge
  - word store: 2 edges
  - load: 3 edges
  - sub-word store: 4 edges
- Throughput: one request outstanding; the next accept is no earlier than the edge after the response handshake.
- MemRead and MemWrite are never both high. MemAddress is held stable from the accept edge until the return to IDLE.
- Reset mid-operation: strobes drop immediately, so an in-flight write is abandoned and memory is unchanged; no response is issued.

Test Plan:
- Reset, then word store 0xDEADBEEF @0x010 with RspReady=1 -> MemWrite high one cycle with MemAddress=4 and MemWriteData=0xDEADBEEF; RspValid 2 edges after accept, RspErr=0.
- Loads after test 1 -> word @0x010 gives 0xDEADBEEF; signed byte @0x013 gives 0xFFFFFFDE; unsigned byte @0x013 gives 0x000000DE; signed half @0x012 gives 0xFFFFDEAD. MemRead high exactly one cycle per load; RspValid 3 edges after accept.
- Byte store 0x55 @0x011 -> MemRead pulse, then MemWrite pulse with 0xDEAD55EF; RspValid 4 edges after accept; a subsequent word load returns 0xDEAD55EF.
- Half @0x011, word @0x012, size 11 @0x010 -> each gives RspErr=1 and RspData=0 one edge after accept; MemRead and MemWrite stay 0.
- Load with RspReady=0 for 5 cycles while ReqValid stays high -> RspValid and RspData held, ReqReady=0, second request not accepted until the edge after the RspReady handshake.
- ResetN pulled low during WRITE of a byte store -> MemWrite falls asynchronously; the memory word stays 0xDEAD55EF; after release ReqReady=1 and RspValid=0.
